// File: rtl/vga_rx_monitor.sv
// Recovers line/frame geometry, pixel coordinates and a per-frame checksum from an hsync/vsync/rgb stream.
// Latency: a sample taken on tick k is reported after tick k+1; frame results update one tick after the vsync leading edge.
// Backpressure: none. The stream is consumed on pix_en ticks, and with pix_en low all state holds and pulses stay low.
//
// Ports:
//   clk, reset (sync, active low), pix_en   : clock, reset, pixel tick
//   hsync, vsync, rgb                        : video stream under observation
//   pix_valid, x, y, pix_rgb                 : active-pixel report (one-clk pulse plus held coordinates/colour)
//   h_total, v_total                         : measured ticks per line, lines per frame
//   locked, frame_done, frame_sum            : geometry lock, frame pulse, checksum of the last frame
module vga_rx_monitor #(
  parameter int   H_ACTIVE = 256,
  parameter int   V_ACTIVE = 240,
  parameter int   H_BP     = 23,
  parameter int   V_BP     = 5,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [2:0]  rgb,
  output logic        pix_valid,
  output logic [8:0]  x,
  output logic [7:0]  y,
  output logic [2:0]  pix_rgb,
  output logic [9:0]  h_total,
  output logic [9:0]  v_total,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_sum
);

  localparam logic [9:0] H_LO = 10'(H_BP);
  localparam logic [9:0] H_HI = 10'(H_BP + H_ACTIVE - 1);
  localparam logic [9:0] V_LO = 10'(V_BP);
  localparam logic [9:0] V_HI = 10'(V_BP + V_ACTIVE - 1);

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3ff) ? v : v + 10'd1;
  endfunction

  // Sync samples are stored as "asserted" flags so the rest of the logic is polarity-free.
  logic        hs_cur, hs_prev, vs_cur, vs_prev;
  logic [2:0]  rgb_s;
  logic [9:0]  hcnt, hpos, lines, vcnt;
  logic        h_seen, primed;
  logic [15:0] acc;
  logic [9:0]  prev_ht, prev_vt;
  logic [1:0]  match_cnt;

  logic        hs_lead, hs_trail, vs_lead, vs_trail, active;
  logic [9:0]  hpos_nx, lines_nx, vcnt_nx, ht_nx;
  logic [1:0]  mc_nx;
  logic [15:0] acc_add;

  always_comb begin
    hs_lead  = hs_cur & ~hs_prev;
    hs_trail = ~hs_cur & hs_prev;
    vs_lead  = vs_cur & ~vs_prev;
    vs_trail = ~vs_cur & vs_prev;

    hpos_nx = hs_trail ? 10'd0 : sat_inc(hpos);

    // A vsync trailing edge on the same tick as an hsync leading edge clears the row count.
    lines_nx = lines;
    if (vs_trail)     lines_nx = 10'd0;
    else if (hs_lead) lines_nx = sat_inc(lines);

    active = (hpos_nx >= H_LO) && (hpos_nx <= H_HI) &&
             (lines_nx >= V_LO) && (lines_nx <= V_HI);

    // The first leading edge after reset only starts the line counter.
    ht_nx = h_total;
    if (hs_lead && h_seen) ht_nx = sat_inc(hcnt);

    // An hsync edge coincident with vsync belongs to the new frame.
    vcnt_nx = vcnt;
    if (vs_lead)      vcnt_nx = {9'd0, hs_lead};
    else if (hs_lead) vcnt_nx = sat_inc(vcnt);

    acc_add = active ? {13'd0, rgb_s} : 16'd0;

    mc_nx = 2'd0;
    if (primed && (ht_nx == prev_ht) && (vcnt == prev_vt))
      mc_nx = (match_cnt == 2'd2) ? 2'd2 : match_cnt + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hs_cur     <= 1'b0;
      hs_prev    <= 1'b0;
      vs_cur     <= 1'b0;
      vs_prev    <= 1'b0;
      rgb_s      <= 3'd0;
      hcnt       <= 10'd0;
      hpos       <= 10'd0;
      lines      <= 10'd0;
      vcnt       <= 10'd0;
      h_seen     <= 1'b0;
      primed     <= 1'b0;
      acc        <= 16'd0;
      prev_ht    <= 10'd0;
      prev_vt    <= 10'd0;
      match_cnt  <= 2'd0;
      pix_valid  <= 1'b0;
      x          <= 9'd0;
      y          <= 8'd0;
      pix_rgb    <= 3'd0;
      h_total    <= 10'd0;
      v_total    <= 10'd0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      frame_sum  <= 16'd0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (pix_en) begin
        hs_cur  <= (hsync == SYNC_POL);
        vs_cur  <= (vsync == SYNC_POL);
        hs_prev <= hs_cur;
        vs_prev <= vs_cur;
        rgb_s   <= rgb;

        hcnt    <= hs_lead ? 10'd0 : sat_inc(hcnt);
        if (hs_lead) h_seen <= 1'b1;
        h_total <= ht_nx;
        hpos    <= hpos_nx;
        lines   <= lines_nx;
        vcnt    <= vcnt_nx;

        if (active) begin
          pix_valid <= 1'b1;
          x         <= 9'(hpos_nx - H_LO);
          y         <= 8'(lines_nx - V_LO);
          pix_rgb   <= rgb_s;
        end

        if (vs_lead) begin
          frame_sum  <= acc;
          acc        <= acc_add;
          v_total    <= vcnt;
          frame_done <= 1'b1;
          primed     <= 1'b1;
          prev_ht    <= ht_nx;
          prev_vt    <= vcnt;
          match_cnt  <= mc_nx;
          locked     <= (mc_nx == 2'd2);
        end else begin
          acc <= acc + acc_add;
        end
      end
    end
  end

endmodule
